// File: rtl/matrix_a_sequencer.sv
// Walks the KxK index space of matrix A, builds each XOF message from rho and
// the index bytes, and launches the polynomial generator once per entry.
module matrix_a_sequencer #(
   parameter int K          = 3,
   parameter int POLY_WORDS = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           transpose,
   input  logic [255:0]   rho,
   input  logic           gen_finish,
   input  logic           abort,
   output logic [0:271]   M,
   output logic           gen_active,
   output logic [8:0]     ram_w_start_offset,
   output logic [1:0]     row,
   output logic [1:0]     col,
   output logic           busy,
   output logic           done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_ADVANCE,
      S_DONE
   } state_t;

   localparam logic [1:0] LAST_IDX = 2'(K - 1);

   state_t       state;
   state_t       state_nxt;
   logic [255:0] rho_q;
   logic         transpose_q;
   logic [1:0]   row_nxt;
   logic [1:0]   col_nxt;

   function automatic logic [0:271] build_msg(input logic [255:0] seed,
                                              input logic         tr,
                                              input logic [1:0]   r,
                                              input logic [1:0]   c);
      logic [7:0] rb;
      logic [7:0] cb;
      rb = {6'b0, r};
      cb = {6'b0, c};
      return tr ? {seed, rb, cb} : {seed, cb, rb};
   endfunction

   function automatic logic [8:0] calc_offset(input logic [1:0] r,
                                              input logic [1:0] c);
      int unsigned idx;
      idx = (32'(r) * 32'(K) + 32'(c)) * 32'(POLY_WORDS);
      return 9'(idx);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_LAUNCH;
         S_LAUNCH:  state_nxt = S_WAIT;
         S_WAIT: begin
            if (gen_finish) begin
               state_nxt = (row == LAST_IDX && col == LAST_IDX) ? S_DONE : S_ADVANCE;
            end
         end
         S_ADVANCE: state_nxt = S_LAUNCH;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      // abort overrides everything, including a same-cycle gen_finish
      if (abort && state != S_IDLE) begin
         state_nxt = S_IDLE;
      end
   end

   always_comb begin
      row_nxt = row;
      col_nxt = col + 2'd1;
      if (col == LAST_IDX) begin
         col_nxt = '0;
         row_nxt = row + 2'd1;
      end
   end

   // Output flags are registered copies of the upcoming state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rho_q              <= '0;
         transpose_q        <= 1'b0;
         row                <= '0;
         col                <= '0;
         M                  <= '0;
         ram_w_start_offset <= '0;
         gen_active         <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         gen_active <= (state_nxt == S_LAUNCH);
         busy       <= (state_nxt != S_IDLE);
         done       <= (state_nxt == S_DONE);
         if (state == S_IDLE && start) begin
            rho_q              <= rho;
            transpose_q        <= transpose;
            row                <= '0;
            col                <= '0;
            M                  <= build_msg(rho, transpose, 2'd0, 2'd0);
            ram_w_start_offset <= '0;
         end else if (state == S_ADVANCE && !abort) begin
            row                <= row_nxt;
            col                <= col_nxt;
            M                  <= build_msg(rho_q, transpose_q, row_nxt, col_nxt);
            ram_w_start_offset <= calc_offset(row_nxt, col_nxt);
         end
      end
   end

   a_launch_single: assert property (@(posedge clk) disable iff (!rst)
      gen_active |=> !gen_active);

   a_offset_in_range: assert property (@(posedge clk) disable iff (!rst)
      gen_active |-> (32'(ram_w_start_offset) < 32'(K * K * POLY_WORDS)));

   a_done_last: assert property (@(posedge clk) disable iff (!rst)
      done |-> (row == LAST_IDX && col == LAST_IDX));

endmodule

// File: tb/tb_matrix_a_sequencer.sv
// Scoreboard bench for matrix_a_sequencer: K=3, K=2 and K=4 instances share a
// clock; expected launches are queued at start and popped on each gen_active.
module tb_matrix_a_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [2:0]     start_v  = '0;
   logic [2:0]     tr_v     = '0;
   logic [2:0]     abort_v  = '0;
   logic [2:0]     inj_fin  = '0;
   logic [2:0]     auto_fin = '0;
   logic [2:0]     auto_en  = '1;
   logic [2:0]     gfin;
   logic [255:0]   rho_v [3] = '{default: '0};

   logic [0:271]   m_o   [3];
   logic [8:0]     off_o [3];
   logic [1:0]     row_o [3];
   logic [1:0]     col_o [3];
   logic [2:0]     ga;
   logic [2:0]     busy_v;
   logic [2:0]     done_v;

   assign gfin = auto_fin | inj_fin;

   matrix_a_sequencer #(.K(3), .POLY_WORDS(32)) u_k3 (
      .clk(clk), .rst(rst), .start(start_v[0]), .transpose(tr_v[0]), .rho(rho_v[0]),
      .gen_finish(gfin[0]), .abort(abort_v[0]), .M(m_o[0]), .gen_active(ga[0]),
      .ram_w_start_offset(off_o[0]), .row(row_o[0]), .col(col_o[0]),
      .busy(busy_v[0]), .done(done_v[0]));

   matrix_a_sequencer #(.K(2), .POLY_WORDS(32)) u_k2 (
      .clk(clk), .rst(rst), .start(start_v[1]), .transpose(tr_v[1]), .rho(rho_v[1]),
      .gen_finish(gfin[1]), .abort(abort_v[1]), .M(m_o[1]), .gen_active(ga[1]),
      .ram_w_start_offset(off_o[1]), .row(row_o[1]), .col(col_o[1]),
      .busy(busy_v[1]), .done(done_v[1]));

   matrix_a_sequencer #(.K(4), .POLY_WORDS(32)) u_k4 (
      .clk(clk), .rst(rst), .start(start_v[2]), .transpose(tr_v[2]), .rho(rho_v[2]),
      .gen_finish(gfin[2]), .abort(abort_v[2]), .M(m_o[2]), .gen_active(ga[2]),
      .ram_w_start_offset(off_o[2]), .row(row_o[2]), .col(col_o[2]),
      .busy(busy_v[2]), .done(done_v[2]));

   typedef struct {
      int           d;
      logic [8:0]   off;
      logic [1:0]   r;
      logic [1:0]   c;
      logic [271:0] m;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   launches [3] = '{0, 0, 0};
   int   done_cnt [3] = '{0, 0, 0};
   int   gen_cnt  [3] = '{0, 0, 0};

   function automatic int kof(input int d);
      case (d)
         0:       return 3;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: row-major walk, offset = linear index * 32, byte order by transpose.
   function automatic void push_expect(input int d, input logic tr, input logic [255:0] s,
                                       input int limit);
      int   k;
      int   n;
      exp_t e;
      k = kof(d);
      n = 0;
      for (int i = 0; i < k; i++) begin
         for (int j = 0; j < k; j++) begin
            if (n < limit) begin
               e.d   = d;
               e.off = 9'((i * k + j) * 32);
               e.r   = 2'(i);
               e.c   = 2'(j);
               e.m   = {s, 8'(tr ? i : j), 8'(tr ? j : i)};
               sb.push_back(e);
            end
            n++;
         end
      end
   endfunction

   function automatic logic [255:0] rand_rho();
      logic [255:0] s;
      for (int w = 0; w < 8; w++) s[w*32 +: 32] = $urandom;
      return s;
   endfunction

   // Generator model: finish pulse 40 cycles after each launch.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst) begin
            gen_cnt[d]  = 0;
            auto_fin[d] = 1'b0;
         end else begin
            auto_fin[d] = 1'b0;
            if (gen_cnt[d] > 0) begin
               gen_cnt[d]--;
               if (gen_cnt[d] == 0) auto_fin[d] = 1'b1;
            end
            if (ga[d] && auto_en[d]) gen_cnt[d] = 40;
         end
      end
   end

   // Monitor: pop and compare on every launch pulse.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (done_v[d]) done_cnt[d]++;
         if (ga[d]) begin
            launches[d]++;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_launch dut%0d: offset %0d row %0d col %0d, none expected",
                        d, off_o[d], row_o[d], col_o[d]);
            end else begin
               e = sb.pop_front();
               chk($sformatf("launch_dut%0d", d), 272'(d), 272'(e.d));
               chk($sformatf("offset_dut%0d", d), 272'(off_o[d]), 272'(e.off));
               chk($sformatf("row_dut%0d", d), 272'(row_o[d]), 272'(e.r));
               chk($sformatf("col_dut%0d", d), 272'(col_o[d]), 272'(e.c));
               chk($sformatf("msg_dut%0d", d), m_o[d], e.m);
            end
         end
      end
   end

   task automatic wait_launch(input int d, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         if (ga[d]) ok = 1'b1;
      end
      if (!ok) chk($sformatf("launch_timeout_dut%0d", d), 272'(ok), 272'(1));
   endtask

   task automatic pulse_start(input int d, input logic tr, input logic [255:0] s);
      @(negedge clk);
      start_v[d] = 1'b1;
      tr_v[d]    = tr;
      rho_v[d]   = s;
      @(negedge clk);
      start_v[d] = 1'b0;
      tr_v[d]    = ~tr;
      rho_v[d]   = rand_rho();
   endtask

   task automatic run(input int d, input logic tr, input logic [255:0] s, input bit noise);
      int k;
      int l0;
      int d0;
      bit got;
      k  = kof(d);
      l0 = launches[d];
      d0 = done_cnt[d];
      push_expect(d, tr, s, k * k);
      pulse_start(d, tr, s);
      got = 1'b0;
      for (int c = 0; c < 6000 && !got; c++) begin
         @(negedge clk);
         start_v[d] = 1'b0;
         inj_fin[d] = 1'b0;
         if (done_v[d]) begin
            got = 1'b1;
         end else if (noise) begin
            if (ga[d]) begin
               start_v[d] = 1'b1;
               inj_fin[d] = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
               start_v[d] = 1'b1;
            end
         end
      end
      chk($sformatf("done_seen_dut%0d", d), 272'(got), 272'(1));
      @(negedge clk);
      chk($sformatf("busy_after_done_dut%0d", d), 272'(busy_v[d]), 272'(0));
      chk($sformatf("launch_count_dut%0d", d), 272'(launches[d] - l0), 272'(k * k));
      chk($sformatf("done_count_dut%0d", d), 272'(done_cnt[d] - d0), 272'(1));
      chk($sformatf("last_offset_dut%0d", d), 272'(off_o[d]), 272'((k * k - 1) * 32));
      chk($sformatf("final_row_dut%0d", d), 272'(row_o[d]), 272'(k - 1));
      chk($sformatf("final_col_dut%0d", d), 272'(col_o[d]), 272'(k - 1));
      chk($sformatf("queue_drained_dut%0d", d), 272'(sb.size()), 272'(0));
   endtask

   task automatic chk_reset_outputs(input int d, input string tag);
      chk($sformatf("%s_M_dut%0d", tag, d), m_o[d], 272'(0));
      chk($sformatf("%s_gen_active_dut%0d", tag, d), 272'(ga[d]), 272'(0));
      chk($sformatf("%s_offset_dut%0d", tag, d), 272'(off_o[d]), 272'(0));
      chk($sformatf("%s_row_dut%0d", tag, d), 272'(row_o[d]), 272'(0));
      chk($sformatf("%s_col_dut%0d", tag, d), 272'(col_o[d]), 272'(0));
      chk($sformatf("%s_busy_dut%0d", tag, d), 272'(busy_v[d]), 272'(0));
      chk($sformatf("%s_done_dut%0d", tag, d), 272'(done_v[d]), 272'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] pat;
      bit           ok;
      int           l0;
      int           d0;

      for (int b = 0; b < 32; b++) pat[255 - 8*b -: 8] = 8'(b);

      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) chk_reset_outputs(d, "por");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      run(0, 1'b0, pat, 1'b0);
      run(0, 1'b1, pat, 1'b0);
      run(1, 1'b0, rand_rho(), 1'b0);
      run(2, 1'b1, rand_rho(), 1'b0);
      run(0, 1'b0, rand_rho(), 1'b1);

      // abort together with the 5th finish; generator driven by hand
      auto_en[0] = 1'b0;
      l0 = launches[0];
      d0 = done_cnt[0];
      push_expect(0, 1'b0, pat, 5);
      pulse_start(0, 1'b0, pat);
      for (int p = 0; p < 5; p++) begin
         if (p > 0) wait_launch(0, ok);
         repeat (3) @(negedge clk);
         inj_fin[0] = 1'b1;
         if (p == 4) abort_v[0] = 1'b1;
         @(negedge clk);
         inj_fin[0] = 1'b0;
         abort_v[0] = 1'b0;
      end
      chk("abort_busy", 272'(busy_v[0]), 272'(0));
      chk("abort_gen_active", 272'(ga[0]), 272'(0));
      repeat (60) @(negedge clk);
      chk("abort_launches", 272'(launches[0] - l0), 272'(5));
      chk("abort_no_done", 272'(done_cnt[0] - d0), 272'(0));
      chk("abort_queue", 272'(sb.size()), 272'(0));
      auto_en[0] = 1'b1;
      run(0, 1'b1, rand_rho(), 1'b0);

      // asynchronous reset in the middle of WAIT
      d0 = done_cnt[0];
      push_expect(0, 1'b0, pat, 9);
      pulse_start(0, 1'b0, pat);
      wait_launch(0, ok);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk_reset_outputs(0, "async_rst");
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_no_done", 272'(done_cnt[0] - d0), 272'(0));
      run(0, 1'b0, rand_rho(), 1'b0);

      for (int r = 0; r < 4; r++) begin
         run($urandom_range(0, 2), 1'($urandom_range(0, 1)), rand_rho(),
             1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_a_sequencer.md
Name: matrix_a_sequencer

Overview:
- Control stage directly upstream of the matrix-A polynomial generator (SHAKE-128 XOF plus rejection/packing stage).
- Walks the K×K index space of public matrix A (or A transposed) and builds each 272-bit XOF message from seed rho and the two index bytes.
- Launches the generator once per polynomial, waits for its finish, and supplies the RAM write base offset so that polynomial (i,j) lands at word (i*K+j)*32.
- Signals done when all K² polynomials are resident in coefficient RAM.

Parameters:
- K, 3, module rank. Legal values 2..4. Fixes loop bounds and offset stride.
- POLY_WORDS, 32, RAM words per polynomial: 256 coefficients / 8 coefficients per 96-bit word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- start  in  1  one-cycle request. Sampled only in IDLE.
- transpose  in  1  0: message uses (j,i) byte order (A). 1: uses (i,j) (A^T). Captured at start.
- rho  in  256  public seed. Captured at start.
- gen_finish  in  1  one-cycle pulse from the generator when a polynomial is fully written.
- abort  in  1  synchronous cancel. Returns the block to IDLE.
- M  out  272  message to the generator, indexed [0:271]. M[0:255]=rho, M[256:263]=first index byte, M[264:271]=second index byte.
- gen_active  out  1  one-cycle launch pulse to the generator.
- ram_w_start_offset  out  9  RAM base word for the current polynomial.
- row  out  2  current i.
- col  out  2  current j.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse after the last polynomial completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. row=col=0; M=0; gen_active=0; ram_w_start_offset=0; busy=0; done=0; rho and transpose registers cleared.
- Registered outputs: all outputs come from registers. No combinational path from any input to any output.
- State IDLE:
  - start=1 captures rho and transpose, clears row and col, then moves to LAUNCH.
  - start is ignored in every other state.
- State LAUNCH (exactly 1 cycle):
  - gen_active=1.
  - M is already valid and stable, having been loaded on entry.
  - ram_w_start_offset = (row*K+col)*POLY_WORDS, computed modulo 512.
  - Next state: WAIT.
- State WAIT:
  - M and ram_w_start_offset held stable.
  - On gen_finish=1: if row=K-1 and col=K-1, go to DONE. Otherwise go to ADVANCE.
- State ADVANCE (1 cycle):
  - If col=K-1, then col←0 and row←row+1. Otherwise col←col+1.
  - Rebuild M and the offset from the new indices, then go to LAUNCH.
- State DONE (1 cycle): done=1, busy drops next cycle, then go to IDLE. row and col keep their final values until the next start.
- Message bytes:
  - transpose=0: M[256:263]={6'b0,col}, M[264:271]={6'b0,row}.
  - transpose=1: M[256:263]={6'b0,row}, M[264:271]={6'b0,col}.
- Launch spacing: gen_active pulses are separated by at least 3 cycles (WAIT, ADVANCE, LAUNCH). Exactly K² pulses per run.
- gen_finish outside WAIT is ignored: no count, no error.
- abort=1 in any non-IDLE state:
  - Next state IDLE. busy=0. gen_active=0. done is not pulsed.
  - abort beats gen_finish in the same cycle.
  - The generator must be reset separately by the system; this block does not issue one.
- Reset asserted mid-run: immediate IDLE per the reset values. No done pulse.
- Offset width: K=4 gives a maximum of 15*32=480 < 512, so no wrap occurs.

Test Plan:
- K=3, transpose=0, rho=0x00..1F pattern, generator model returns finish 40 cycles after each active:
  - exactly 9 gen_active pulses.
  - offsets 0,32,64,96,128,160,192,224,256.
  - pulse 4 (row=1, col=0) has M[256:263]=0x00 and M[264:271]=0x01.
  - done once; busy low afterwards.
- Same run with transpose=1: pulse 4 has M[256:263]=0x01 and M[264:271]=0x00; rho bits unchanged.
- K=4 and K=2 builds:
  - last offset 480 with 16 launches (K=4).
  - last offset 96 with 4 launches (K=2).
- start asserted while busy, plus a spurious gen_finish during LAUNCH: sequence unchanged, no extra launches, offsets unaltered.
- abort in WAIT of the 5th polynomial, asserted in the same cycle as gen_finish: state IDLE next cycle, no done, no further gen_active. A fresh start then restarts at offset 0.
- rst driven low mid-WAIT, asynchronously between edges: all outputs reach reset values without a clock edge. After release, start gives a full normal run.
